// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the triggered ADC snapshot buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
package adc_capture_pkg;

   localparam int ADC_DATA_W = 12;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      WAIT_TRIG,
      POST,
      DONE
   } state_t;

   // One buffer entry: channel 1 in the upper half, channel 0 in the lower.
   typedef struct packed {
      logic [ADC_DATA_W-1:0] ch1;
      logic [ADC_DATA_W-1:0] ch0;
   } sample_pair_t;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port single-clock sample RAM with registered read.
// Latency: 1 cycle write-to-read, rdata registered 1 cycle after raddr.
// Backpressure: none; read-during-write to the same address returns old data.
// Ports: clk, rst_n (clears read register only), we/waddr/wdata write side,
//        raddr/rdata read side.
module adc_capture_ram #(
   parameter int W  = 24,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
   end

endmodule

// File: rtl/adc_capture.sv
// Triggered snapshot buffer for the dual-channel ADC sample stream.
// Latency: 1 cycle input register; rd_data 1 cycle after rd_addr.
// Backpressure: none; samples arrive every cycle and are stored on decimation strobes.
// Ports: sys_clk/rst_n; ad_data_ch0/1 samples; arm, force_trig, trig_ch, trig_rising,
//        trig_level, pretrig, decim config (latched on arm); busy, done, start_addr,
//        trig_pos status; rd_addr/rd_data readout.
// Build option: ADC_CAPTURE_SIGNED_EN converts offset-binary samples to two's
//        complement and makes trigger comparisons signed.
module adc_capture
   import adc_capture_pkg::*;
#(
   parameter int DATA_W     = ADC_DATA_W,
   parameter int DEPTH_LOG2 = 10,
   parameter int DECIM_W    = 16
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     ad_data_ch0,
   input  logic [DATA_W-1:0]     ad_data_ch1,
   input  logic                  arm,
   input  logic                  force_trig,
   input  logic                  trig_ch,
   input  logic                  trig_rising,
   input  logic [DATA_W-1:0]     trig_level,
   input  logic [DEPTH_LOG2-1:0] pretrig,
   input  logic [DECIM_W-1:0]    decim,
   output logic                  busy,
   output logic                  done,
   output logic [DEPTH_LOG2-1:0] start_addr,
   output logic [DEPTH_LOG2-1:0] trig_pos,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [2*DATA_W-1:0]   rd_data
);

   localparam logic [DEPTH_LOG2-1:0] A_ZERO = '0;
   localparam logic [DEPTH_LOG2-1:0] A_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DECIM_W-1:0]    D_ONE  = {{(DECIM_W-1){1'b0}}, 1'b1};

   state_t state_q, state_d;

   logic [DATA_W-1:0]     ch0_q, ch1_q, ch0_s, ch1_s, cur, prev_q, trig_level_q;
   logic [DECIM_W-1:0]    decim_q, dc_q;
   logic [DEPTH_LOG2-1:0] pretrig_q, wp_q, cnt_q, post_cnt_q;
   logic                  trig_ch_q, trig_rising_q, prev_vld_q;
   logic                  strobe, s_ge, p_ge, level_hit, trig_hit, we;

   // Input register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ch0_q <= '0;
         ch1_q <= '0;
      end else begin
         ch0_q <= ad_data_ch0;
         ch1_q <= ad_data_ch1;
      end
   end

`ifdef ADC_CAPTURE_SIGNED_EN
   // Offset-binary to two's complement: flip the MSB.
   assign ch0_s = {~ch0_q[DATA_W-1], ch0_q[DATA_W-2:0]};
   assign ch1_s = {~ch1_q[DATA_W-1], ch1_q[DATA_W-2:0]};
   assign cur   = trig_ch_q ? ch1_s : ch0_s;
   assign s_ge  = $signed(cur)    >= $signed(trig_level_q);
   assign p_ge  = $signed(prev_q) >= $signed(trig_level_q);
`else
   assign ch0_s = ch0_q;
   assign ch1_s = ch1_q;
   assign cur   = trig_ch_q ? ch1_s : ch0_s;
   assign s_ge  = cur    >= trig_level_q;
   assign p_ge  = prev_q >= trig_level_q;
`endif

   assign strobe    = (dc_q == decim_q);
   // A level crossing needs a previous strobed sample taken since arm.
   assign level_hit = prev_vld_q && (trig_rising_q ? (!p_ge && s_ge) : (p_ge && !s_ge));
   assign trig_hit  = strobe && (force_trig || level_hit);

   // FSM: state register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (arm) begin
         state_d = PRE;
      end else begin
         case (state_q)
            // The strobe that fills the last pre-trigger slot also moves us on,
            // so no sample is dropped between PRE and WAIT_TRIG.
            PRE:       if (pretrig_q == A_ZERO || (strobe && (cnt_q + A_ONE) == pretrig_q))
                          state_d = WAIT_TRIG;
            WAIT_TRIG: if (trig_hit) state_d = POST;
            POST:      if (post_cnt_q == A_ZERO || (strobe && post_cnt_q == A_ONE))
                          state_d = DONE;
            default:   state_d = state_q;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      we   = 1'b0;
      case (state_q)
         PRE: begin
            busy = 1'b1;
            we   = strobe && (pretrig_q != A_ZERO);
         end
         WAIT_TRIG: begin
            busy = 1'b1;
            we   = strobe;
         end
         POST: begin
            busy = 1'b1;
            we   = strobe && (post_cnt_q != A_ZERO);
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
      if (arm) we = 1'b0;
   end

   // Datapath: config latch, decimation, pointers, trigger bookkeeping
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pretrig_q     <= '0;
         decim_q       <= '0;
         trig_level_q  <= '0;
         trig_ch_q     <= 1'b0;
         trig_rising_q <= 1'b0;
         dc_q          <= '0;
         wp_q          <= '0;
         cnt_q         <= '0;
         post_cnt_q    <= '0;
         prev_q        <= '0;
         prev_vld_q    <= 1'b0;
         trig_pos      <= '0;
         start_addr    <= '0;
      end else if (arm) begin
         // pretrig is DEPTH_LOG2 wide, so it can never exceed DEPTH-1.
         pretrig_q     <= pretrig;
         decim_q       <= decim;
         trig_level_q  <= trig_level;
         trig_ch_q     <= trig_ch;
         trig_rising_q <= trig_rising;
         dc_q          <= '0;
         wp_q          <= '0;
         cnt_q         <= '0;
         post_cnt_q    <= '0;
         prev_vld_q    <= 1'b0;
      end else begin
         dc_q <= strobe ? '0 : dc_q + D_ONE;
         if (we) wp_q <= wp_q + A_ONE;
         if (strobe && (state_q == PRE || state_q == WAIT_TRIG)) begin
            prev_q     <= cur;
            prev_vld_q <= 1'b1;
         end
         if (state_q == PRE && strobe) cnt_q <= cnt_q + A_ONE;
         if (state_q == WAIT_TRIG && trig_hit) begin
            trig_pos   <= wp_q;
            start_addr <= wp_q - pretrig_q;
            post_cnt_q <= ~pretrig_q;          // DEPTH-1-pretrig
         end
         if (state_q == POST && strobe && post_cnt_q != A_ZERO)
            post_cnt_q <= post_cnt_q - A_ONE;
      end
   end

   adc_capture_ram #(
      .W  (2*DATA_W),
      .AW (DEPTH_LOG2)
   ) u_ram (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wp_q),
      .wdata ({ch1_s, ch0_s}),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_adc_capture.sv
// Directed self-checking bench for adc_capture with a 16-entry buffer.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_capture;
   import adc_capture_pkg::*;

   localparam int DW  = 12;
   localparam int AW  = 4;
   localparam int DCW = 16;

   logic          sys_clk, rst_n;
   logic [DW-1:0] ad_data_ch0, ad_data_ch1, trig_level;
   logic          arm, force_trig, trig_ch, trig_rising;
   logic [AW-1:0] pretrig, start_addr, trig_pos, rd_addr;
   logic [DCW-1:0] decim;
   logic          busy, done;
   logic [2*DW-1:0] rd_data;

   adc_capture #(.DATA_W(DW), .DEPTH_LOG2(AW), .DECIM_W(DCW)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .ad_data_ch0(ad_data_ch0), .ad_data_ch1(ad_data_ch1),
      .arm(arm), .force_trig(force_trig), .trig_ch(trig_ch), .trig_rising(trig_rising),
      .trig_level(trig_level), .pretrig(pretrig), .decim(decim),
      .busy(busy), .done(done), .start_addr(start_addr), .trig_pos(trig_pos),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic          ramp_on = 1'b0;
   logic [DW-1:0] ramp_inc = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge sys_clk);
      #1;
      if (ramp_on) ad_data_ch0 = ad_data_ch0 + ramp_inc;
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic read_word(input logic [AW-1:0] a, output sample_pair_t d);
      rd_addr = a;
      step();
      d = rd_data;
   endtask

   // Steps until done; returns number of steps taken. Expiry counts as a failure.
   task automatic wait_done(input string tag, input int budget, output int n);
      n = 0;
      while (!done && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   initial begin
      sample_pair_t d, prev;
      int           n, t_mark;
      logic         prev_busy;
      logic [AW-1:0] a;

      rst_n = 1'b0; arm = 1'b0; force_trig = 1'b0; trig_ch = 1'b0; trig_rising = 1'b1;
      trig_level = '0; pretrig = '0; decim = '0; rd_addr = '0;
      ad_data_ch0 = '0; ad_data_ch1 = '0;
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_start_addr", 32'(start_addr), 0);
      check("rst_trig_pos", 32'(trig_pos), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      #5 rst_n = 1'b1;
      step();

`ifndef ADC_CAPTURE_SIGNED_EN
      // Rising trigger on a +16 ramp, 4 pre-trigger samples.
      decim = '0; pretrig = 4'd4; trig_level = 12'h800; trig_ch = 1'b0; trig_rising = 1'b1;
      ad_data_ch0 = '0; ramp_inc = 12'd16; ramp_on = 1'b1;
      arm_pulse();
      check("t1_busy_after_arm", 32'(busy), 1);
      check("t1_done_after_arm", 32'(done), 0);
      t_mark = -1; n = 0; prev_busy = busy;
      while (!done && n < 300) begin
         prev_busy = busy;
         step();
         n++;
         if (ad_data_ch0 == 12'h800 && t_mark < 0) t_mark = n;
      end
      check("t1_done", 32'(done), 1);
      check("t1_done_latency", 32'(n - t_mark), 32'd13);
      check("t1_busy_before_done", 32'(prev_busy), 1);
      check("t1_busy_at_done", 32'(busy), 0);
      check("t1_trig_pos", 32'(trig_pos), 32'(4'(start_addr + 4'd4)));
      ramp_on = 1'b0;
      for (int i = 0; i < 16; i++) begin
         a = start_addr + 4'(i);
         read_word(a, d);
         check($sformatf("t1_buf%0d", i), 32'(d.ch0), 32'h7C0 + 32'(16 * i));
      end

      // Decimation by 4 with forced trigger.
      decim = 16'd3; pretrig = 4'd4; force_trig = 1'b1;
      ad_data_ch0 = '0; ramp_inc = 12'd1; ramp_on = 1'b1;
      arm_pulse();
      wait_done("t2_done", 200, n);
      ramp_on = 1'b0; force_trig = 1'b0;
      read_word(start_addr, prev);
      for (int i = 1; i < 16; i++) begin
         a = start_addr + 4'(i);
         read_word(a, d);
         check($sformatf("t2_step%0d", i), 32'(d.ch0 - prev.ch0), 32'd4);
         prev = d;
      end

      // Falling trigger on ch1 with no pre-trigger samples.
      decim = '0; pretrig = '0; trig_ch = 1'b1; trig_rising = 1'b0; trig_level = 12'h800;
      ad_data_ch0 = '0; ad_data_ch1 = 12'hA00;
      arm_pulse();
      repeat (4) step();
      ad_data_ch1 = 12'h300;
      wait_done("t3_done", 40, n);
      check("t3_done_latency", 32'(n), 32'd17);
      check("t3_trig_eq_start", 32'(trig_pos), 32'(start_addr));
      for (int i = 0; i < 16; i++) begin
         a = start_addr + 4'(i);
         read_word(a, d);
         check($sformatf("t3_buf%0d", i), 32'(d.ch1), 32'h300);
      end

      // First strobe after arm must not trigger; a genuine dip-and-return does.
      trig_ch = 1'b0; trig_rising = 1'b1; trig_level = 12'h800; pretrig = '0; decim = '0;
      ad_data_ch0 = 12'h900; ad_data_ch1 = '0;
      arm_pulse();
      repeat (20) step();
      check("t4_busy_held", 32'(busy), 1);
      check("t4_no_done", 32'(done), 0);
      ad_data_ch0 = 12'h100;
      step(); step();
      ad_data_ch0 = 12'h900;
      wait_done("t4_done", 40, n);
      check("t4_done_latency", 32'(n), 32'd17);
      read_word(trig_pos, d);
      check("t4_trig_sample", 32'(d.ch0), 32'h900);
`endif

      // Restart mid-POST, then asynchronous reset mid-POST.
      trig_ch = 1'b0; pretrig = 4'd2; decim = '0; force_trig = 1'b1;
      ad_data_ch0 = '0; ramp_inc = 12'd1; ramp_on = 1'b1;
      arm_pulse();
      repeat (6) step();
      check("t5_in_post", 32'(dut.state_q), 32'(POST));
      arm_pulse();
      check("t5_rearm_state", 32'(dut.state_q), 32'(PRE));
      check("t5_rearm_wp", 32'(dut.wp_q), 0);
      check("t5_rearm_done", 32'(done), 0);
      check("t5_rearm_busy", 32'(busy), 1);
      repeat (5) step();
      check("t5_done_stays_low", 32'(done), 0);
      check("t5_busy_before_rst", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_busy", 32'(busy), 0);
      check("t5_async_done", 32'(done), 0);
      check("t5_async_trig_pos", 32'(trig_pos), 0);
      check("t5_async_rd_data", 32'(rd_data), 0);
      ramp_on = 1'b0; force_trig = 1'b0;
      #3 rst_n = 1'b1;
      step();

`ifdef ADC_CAPTURE_SIGNED_EN
      // Offset-binary input, signed trigger at zero.
      trig_ch = 1'b0; trig_rising = 1'b1; trig_level = 12'h000; pretrig = 4'd2; decim = '0;
      ad_data_ch0 = 12'h000;
      arm_pulse();
      repeat (6) step();
      check("s_no_early_trig", 32'(busy), 1);
      ad_data_ch0 = 12'h7FF;
      step();
      ad_data_ch0 = 12'h801;
      wait_done("s_done", 40, n);
      read_word(start_addr, d);
      check("s_stored_zero_input", 32'(d.ch0), 32'h800);
      a = start_addr + 4'd1;
      read_word(a, d);
      check("s_stored_minus1", 32'(d.ch0), 32'hFFF);
      read_word(trig_pos, d);
      check("s_trig_sample", 32'(d.ch0), 32'h001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
